// File: rtl/rst_req_gen.sv
// rst_req_gen: source side of the core reset net.
// Collects level-sensitive reset requests and drives a registered,
// glitch-free active-low reset with a guaranteed minimum low time.
// After power-on it holds reset, then waits a quiet window before it
// accepts new requests again.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ASSERT  | o_rst_n low; counting hold time, any request restarts it
// QUIET   | o_rst_n high, still busy; requests ignored until last cycle
// IDLE    | o_rst_n high, not busy; any request re-enters ASSERT
module rst_req_gen #(
  parameter int NSRC         = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int QUIET_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] i_req,
  output logic            o_rst_n,
  output logic            o_busy,
  output logic            o_ack,
  output logic [NSRC-1:0] o_cause
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > QUIET_CYCLES) ? HOLD_CYCLES : QUIET_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_CYCLES);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_QUIET  = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [CW-1:0]     cnt_inc;
  logic              req_any;

  logic              rst_out_nxt;
  logic              busy_nxt;
  logic              ack_nxt;
  logic [NSRC-1:0]   cause_nxt;

  assign req_any = |i_req;

  // The compare values stay below CNT_MAX, so saturation only guards
  // against an illegal state ever letting the counter wrap.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  // State and counter register; power-on behaves like a request with no cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ASSERT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_ASSERT: begin
        if (req_any) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_QUIET;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_QUIET: begin
        if (cnt == QUIET_LAST) begin
          cnt_nxt   = '0;
          state_nxt = req_any ? ST_ASSERT : ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_IDLE: begin
        if (req_any) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, so the output flops switch on
  // the same edge as the state register and carry no decode glitches.
  always_comb begin
    rst_out_nxt = (state_nxt != ST_ASSERT);
    busy_nxt    = (state_nxt != ST_IDLE);
    ack_nxt     = (state == ST_QUIET) && (state_nxt == ST_IDLE);
    cause_nxt   = o_cause;
    if (state == ST_ASSERT) begin
      if (req_any) begin
        cause_nxt = o_cause | i_req;
      end
    end else if (state_nxt == ST_ASSERT) begin
      // A new sequence starts: the previous cause is replaced, not merged.
      cause_nxt = i_req;
    end
  end

  // Registered outputs; i_req only ever reaches flop inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rst_n <= 1'b0;
      o_busy  <= 1'b1;
      o_ack   <= 1'b0;
      o_cause <= '0;
    end else begin
      o_rst_n <= rst_out_nxt;
      o_busy  <= busy_nxt;
      o_ack   <= ack_nxt;
      o_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: a timestamp-based reference model (release and
// quiet-end edges computed from request times) checked every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_rst_req_gen;

  localparam int H0 = 16;
  localparam int Q0 = 4;
  localparam int H1 = 1;
  localparam int Q1 = 1;

  localparam int M_ASSERT = 0;
  localparam int M_QUIET  = 1;
  localparam int M_IDLE   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req0 = 2'b00;
  logic [0:0] req1 = 1'b0;

  logic       rst0, busy0, ack0;
  logic [1:0] cause0;
  logic       rst1, busy1, ack1;
  logic [0:0] cause1;

  always #5 clk = ~clk;

  rst_req_gen #(.NSRC(2), .HOLD_CYCLES(H0), .QUIET_CYCLES(Q0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_req(req0),
    .o_rst_n(rst0), .o_busy(busy0), .o_ack(ack0), .o_cause(cause0)
  );

  rst_req_gen #(.NSRC(1), .HOLD_CYCLES(H1), .QUIET_CYCLES(Q1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_req(req1),
    .o_rst_n(rst1), .o_busy(busy1), .o_ack(ack1), .o_cause(cause1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per instance, the edge index at which reset will be
  // released and the edge at which the quiet window ends.
  int         m_mode[2];
  int         m_t[2];
  int         m_rel[2];
  int         m_done[2];
  logic [1:0] m_cause[2];
  bit         m_ack[2];

  task automatic m_reset(input int d, input int h);
    m_mode[d]  = M_ASSERT;
    m_t[d]     = 0;
    m_rel[d]   = h;
    m_done[d]  = 0;
    m_cause[d] = 2'b00;
    m_ack[d]   = 1'b0;
  endtask

  task automatic m_step(input int d, input logic [1:0] r, input int h, input int q);
    m_t[d]++;
    m_ack[d] = 1'b0;
    if (m_mode[d] == M_ASSERT) begin
      if (r != 0) begin
        m_cause[d] = m_cause[d] | r;
        m_rel[d]   = m_t[d] + h;
      end else if (m_t[d] >= m_rel[d]) begin
        m_mode[d] = M_QUIET;
        m_done[d] = m_t[d] + q;
      end
    end else if (m_mode[d] == M_QUIET) begin
      if (m_t[d] == m_done[d]) begin
        if (r != 0) begin
          m_mode[d]  = M_ASSERT;
          m_rel[d]   = m_t[d] + h;
          m_cause[d] = r;
        end else begin
          m_mode[d] = M_IDLE;
          m_ack[d]  = 1'b1;
        end
      end
    end else begin
      if (r != 0) begin
        m_mode[d]  = M_ASSERT;
        m_rel[d]   = m_t[d] + h;
        m_cause[d] = r;
      end
    end
  endtask

  initial begin
    m_reset(0, H0);
    m_reset(1, H1);
  end

  always @(negedge rst_n) begin
    m_reset(0, H0);
    m_reset(1, H1);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_reset(0, H0);
      m_reset(1, H1);
    end else begin
      m_step(0, req0, H0, Q0);
      m_step(1, {1'b0, req1}, H1, Q1);
    end
  end

  // Low-time / ack-timing monitor for literal checks.
  int samp = 0;
  int low_run = 0;
  int last_low = 0;
  int rise_samp = 0;
  int last_ack_samp = 0;
  int ack_count = 0;
  int low1_run = 0;
  int last_low1 = 0;

  // Per-cycle comparison against the model, then monitor update.
  always @(posedge clk) begin
    #1;
    check("rst_n0", rst0,   (m_mode[0] != M_ASSERT));
    check("busy0",  busy0,  (m_mode[0] != M_IDLE));
    check("ack0",   ack0,   m_ack[0]);
    check("cause0", cause0, m_cause[0]);
    check("rst_n1", rst1,   (m_mode[1] != M_ASSERT));
    check("busy1",  busy1,  (m_mode[1] != M_IDLE));
    check("ack1",   ack1,   m_ack[1]);
    check("cause1", cause1, m_cause[1][0]);

    samp++;
    if (!rst_n) begin
      low_run = 1;
    end else if (!rst0) begin
      low_run++;
    end else if (low_run > 0) begin
      last_low  = low_run;
      low_run   = 0;
      rise_samp = samp;
      check("min_low0", (last_low >= H0), 1'b1);
    end
    if (ack0) begin
      ack_count++;
      last_ack_samp = samp;
    end

    if (!rst_n) begin
      low1_run = 1;
    end else if (!rst1) begin
      low1_run++;
    end else if (low1_run > 0) begin
      last_low1 = low1_run;
      low1_run  = 0;
    end
  end

  task automatic wait_rise0(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!rst0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, rst0, 1'b1);
  endtask

  task automatic wait_idle0(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, busy0, 1'b0);
  endtask

  initial begin
    int req_samp;
    int ack_before;
    int burst;
    logic [1:0] bval;

    #1 rst_n = 1'b0;
    #1;
    check("por_rst_n", rst0, 1'b0);
    check("por_busy", busy0, 1'b1);
    check("por_ack", ack0, 1'b0);
    check("por_cause", cause0, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Power-on sequence
    wait_rise0("por_rise");
    check("por_low_len", last_low, H0);
    check("por_cause_rise", cause0, 2'b00);
    wait_idle0("por_idle");
    check("por_ack_gap", last_ack_samp - rise_samp, Q0);
    check("por_ack_count", ack_count, 1);
    check("por_cause_idle", cause0, 2'b00);

    // Single-cycle request from IDLE
    ack_before = ack_count;
    req0 = 2'b01;
    req_samp = samp + 1;
    @(negedge clk);
    req0 = 2'b00;
    wait_rise0("pulse_rise");
    check("pulse_low_len", last_low, 16);
    check("pulse_cause", cause0, 2'b01);
    wait_idle0("pulse_idle");
    check("pulse_req_to_ack", last_ack_samp - req_samp, 20);
    check("pulse_ack_once", ack_count - ack_before, 1);

    // Held request with a second source joining mid-way
    for (int i = 0; i < 10; i++) begin
      req0 = (i == 5) ? 2'b11 : 2'b01;
      @(negedge clk);
    end
    req0 = 2'b00;
    wait_rise0("held_rise");
    check("held_low_len", last_low, 25);
    check("held_cause", cause0, 2'b11);
    wait_idle0("held_idle");

    // Request during QUIET (not on its last cycle) is ignored
    ack_before = ack_count;
    req0 = 2'b01;
    @(negedge clk);
    req0 = 2'b00;
    wait_rise0("qign_rise");
    @(negedge clk);
    req0 = 2'b10;
    @(negedge clk);
    req0 = 2'b00;
    wait_idle0("qign_idle");
    check("qign_ack", ack_count - ack_before, 1);
    check("qign_cause", cause0, 2'b01);
    check("qign_rst_n", rst0, 1'b1);

    // Request on the last QUIET cycle re-asserts without an ack
    ack_before = ack_count;
    req0 = 2'b01;
    @(negedge clk);
    req0 = 2'b00;
    wait_rise0("qre_rise");
    @(negedge clk);
    req0 = 2'b10;
    @(negedge clk);
    req0 = 2'b00;
    @(negedge clk);
    req0 = 2'b10;
    @(negedge clk);
    req0 = 2'b00;
    check("qre_rst_n", rst0, 1'b0);
    check("qre_cause", cause0, 2'b10);
    check("qre_no_ack", ack_count - ack_before, 0);
    wait_rise0("qre_rise2");
    check("qre_low_len", last_low, 16);
    wait_idle0("qre_idle");
    check("qre_cause_idle", cause0, 2'b10);

    // Asynchronous reset in the middle of ASSERT
    req0 = 2'b01;
    @(negedge clk);
    req0 = 2'b00;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_n", rst0, 1'b0);
    check("mid_busy", busy0, 1'b1);
    check("mid_ack", ack0, 1'b0);
    check("mid_cause", cause0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise0("mid_rise");
    check("mid_low_len", last_low, H0);
    check("mid_cause_rise", cause0, 2'b00);
    wait_idle0("mid_idle");

    // HOLD=1, QUIET=1, single-source corner
    check("c1_idle", busy1, 1'b0);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    check("c1_low", rst1, 1'b0);
    @(negedge clk);
    check("c1_high", rst1, 1'b1);
    check("c1_low_len", last_low1, 1);
    check("c1_cause", cause1, 1'b1);

    // Randomized bursts, single-cycle requests and occasional resets
    burst = 0;
    bval = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if (burst > 0) burst--;
      else if ($urandom_range(0, 24) == 0) begin
        burst = $urandom_range(1, 12);
        bval = 2'($urandom_range(1, 3));
      end
      req0 = (burst > 0) ? bval : 2'b00;
      req1 = 1'($urandom_range(0, 9) == 0);
    end
    req0 = 2'b00;
    req1 = 1'b0;
    rst_n = 1'b1;
    wait_idle0("final_idle");
    @(negedge clk);
    check("final_idle1", busy1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
